ga23_cpu_bridge: RTL and testbench

//  CPU-side initiator for the GA23 VRAM/register port. Turns a CPU request (mem or io, byte enables)

---
 rtl/ga23_pkg.sv | 45 ++++
 rtl/ga23_cpu_bridge.sv | 216 +++++++++++++++++++++
 tb/tb_ga23_cpu_bridge.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ga23_pkg.sv
// ga23_pkg
//   Shared types and helpers for the GA23 CPU-side bridge.
//   - bridge_state_t : bridge FSM states (RMW states exist only when
//                      GA23_BRIDGE_RMW_EN is defined)
//   - GA23_IO_BASE   : base of the GA23 register (io) window
//   - lane_fill      : replicate the enabled byte lane into both lanes
//   - lane_merge     : merge enabled write lanes over read-back data
//                      (GA23_BRIDGE_RMW_EN only)
package ga23_pkg;

    localparam logic [7:0] GA23_IO_BASE = 8'h80;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        GAP
`ifdef GA23_BRIDGE_RMW_EN
        ,
        RMW_RD,
        RMW_WR
`endif
    } bridge_state_t;

    // A single-lane write becomes a full-word write with the enabled byte
    // in both lanes; GA23 has no byte strobes of its own.
    function automatic logic [15:0] lane_fill(input logic [1:0] be, input logic [15:0] data);
        logic [15:0] res;
        case (be)
            2'b01:   res = {data[7:0], data[7:0]};
            2'b10:   res = {data[15:8], data[15:8]};
            default: res = data;
        endcase
        return res;
    endfunction

`ifdef GA23_BRIDGE_RMW_EN
    function automatic logic [15:0] lane_merge(input logic [1:0] be, input logic [15:0] wr_data,
                                               input logic [15:0] rd_data);
        return {be[1] ? wr_data[15:8] : rd_data[15:8],
                be[0] ? wr_data[7:0]  : rd_data[7:0]};
    endfunction
`endif

endpackage

// File: rtl/ga23_cpu_bridge.sv
// ga23_cpu_bridge
//   CPU-side initiator for the GA23 VRAM/register port. A CPU request is
//   turned into the GA23 mem_cs/mem_rd/mem_wr/io_wr strobe protocol; the
//   bridge waits on GA23 busy, returns read data and a one-cycle ack.
//
// Parameters
//   TIMEOUT : busy-low cycles tolerated in ISSUE before strobes drop and
//             the access is retried (>= 4)
//   ADDR_W  : GA23 byte address width
//
// Ports
//   clk, reset             : clock, synchronous active-high reset
//   cpu_req/io/we/be/addr/wdata : CPU request (sampled in IDLE only)
//   cpu_rdata, cpu_ack     : read data and one-cycle completion pulse
//   ga_cs/rd/wr/io_wr      : GA23 strobes
//   ga_addr, ga_din        : GA23 address and write data
//   ga_dout, ga_busy       : GA23 read data and busy
//
// Build option
//   GA23_BRIDGE_RMW_EN : partial mem writes run read-modify-write instead
//                        of replicating the enabled byte into both lanes.
module ga23_cpu_bridge
    import ga23_pkg::*;
#(
    parameter int TIMEOUT = 64,
    parameter int ADDR_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_io,
    input  logic              cpu_we,
    input  logic [1:0]        cpu_be,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [15:0]       cpu_wdata,
    output logic [15:0]       cpu_rdata,
    output logic              cpu_ack,
    output logic              ga_cs,
    output logic              ga_rd,
    output logic              ga_wr,
    output logic              ga_io_wr,
    output logic [ADDR_W-1:0] ga_addr,
    output logic [15:0]       ga_din,
    input  logic [15:0]       ga_dout,
    input  logic              ga_busy
);

    localparam int CNT_W = $clog2(TIMEOUT);

    bridge_state_t     state, state_next;
    logic              op_we;
    logic [ADDR_W-1:0] addr_q;
    logic [15:0]       wdata_q;
    logic [15:0]       rdata_q;
    logic              ack_q;
    logic              io_pulse_q;
    logic [CNT_W-1:0]  retry_cnt;
    logic              retry_q;
    logic              low_seen;
    logic [1:0]        be_n;
    logic              timeout_hit;
`ifdef GA23_BRIDGE_RMW_EN
    logic [1:0]        op_be;
    logic              rmw_q;
    logic [15:0]       rd_buf;
`endif

    assign be_n        = (cpu_be == 2'b00) ? 2'b11 : cpu_be;
    assign timeout_hit = (retry_cnt == CNT_W'(TIMEOUT - 1));

    assign cpu_rdata = rdata_q;
    assign cpu_ack   = ack_q;
    assign ga_io_wr  = io_pulse_q;
    assign ga_addr   = addr_q;
    assign ga_din    = wdata_q;

    // Next state and strobes. low_seen guards against a busy that was
    // already high when ISSUE was entered: that busy belongs to someone
    // else's access, so we only treat busy as ours once it was seen low.
    always_comb begin
        state_next = state;
        ga_cs      = 1'b0;
        ga_rd      = 1'b0;
        ga_wr      = 1'b0;
        case (state)
            IDLE: begin
                if (cpu_req && !cpu_io) state_next = ISSUE;
            end
            ISSUE: begin
                ga_cs = 1'b1;
                ga_rd = ~op_we;
                ga_wr = op_we;
                if (ga_busy && low_seen)       state_next = WAIT;
                else if (!ga_busy && timeout_hit) state_next = GAP;
            end
            WAIT: begin
                ga_cs = 1'b1;
                ga_rd = ~op_we;
                ga_wr = op_we;
                if (!ga_busy) begin
`ifdef GA23_BRIDGE_RMW_EN
                    state_next = rmw_q ? RMW_RD : GAP;
`else
                    state_next = GAP;
`endif
                end
            end
            GAP: begin
                state_next = retry_q ? ISSUE : IDLE;
            end
`ifdef GA23_BRIDGE_RMW_EN
            RMW_RD: state_next = RMW_WR;
            RMW_WR: state_next = ISSUE;
`endif
            default: state_next = IDLE;
        endcase
    end

    // State register plus request latches, timeout counter and result
    // capture. ack and io_wr default low so they are single-cycle pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            op_we      <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            ack_q      <= 1'b0;
            io_pulse_q <= 1'b0;
            retry_cnt  <= '0;
            retry_q    <= 1'b0;
            low_seen   <= 1'b0;
`ifdef GA23_BRIDGE_RMW_EN
            op_be      <= 2'b11;
            rmw_q      <= 1'b0;
            rd_buf     <= '0;
`endif
        end else begin
            state      <= state_next;
            ack_q      <= 1'b0;
            io_pulse_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (cpu_req) begin
                        op_we     <= cpu_we;
                        retry_cnt <= '0;
                        retry_q   <= 1'b0;
                        low_seen  <= 1'b0;
                        if (cpu_io) begin
                            addr_q     <= cpu_addr;
                            wdata_q    <= cpu_wdata;
                            io_pulse_q <= cpu_we;
                            ack_q      <= 1'b1;
                            if (!cpu_we) rdata_q <= 16'h0000;
                        end else begin
                            addr_q <= {cpu_addr[ADDR_W-1:1], 1'b0};
`ifdef GA23_BRIDGE_RMW_EN
                            wdata_q <= cpu_wdata;
                            op_be   <= be_n;
                            rmw_q   <= cpu_we && (be_n != 2'b11);
                            op_we   <= cpu_we && (be_n == 2'b11);
`else
                            wdata_q <= lane_fill(be_n, cpu_wdata);
`endif
                        end
                    end
                end
                ISSUE: begin
                    if (!ga_busy) begin
                        low_seen <= 1'b1;
                        if (timeout_hit) begin
                            retry_cnt <= '0;
                            retry_q   <= 1'b1;
                        end else begin
                            retry_cnt <= retry_cnt + 1'b1;
                        end
                    end
                end
                WAIT: begin
                    if (!ga_busy) begin
                        retry_cnt <= '0;
                        retry_q   <= 1'b0;
`ifdef GA23_BRIDGE_RMW_EN
                        if (rmw_q) begin
                            rd_buf <= ga_dout;
                        end else begin
                            ack_q <= 1'b1;
                            if (!op_we) rdata_q <= ga_dout;
                        end
`else
                        ack_q <= 1'b1;
                        if (!op_we) rdata_q <= ga_dout;
`endif
                    end
                end
                GAP: begin
                    retry_q  <= 1'b0;
                    low_seen <= 1'b0;
                end
`ifdef GA23_BRIDGE_RMW_EN
                RMW_RD: begin
                    wdata_q <= lane_merge(op_be, wdata_q, rd_buf);
                end
                RMW_WR: begin
                    op_we     <= 1'b1;
                    rmw_q     <= 1'b0;
                    low_seen  <= 1'b0;
                    retry_cnt <= '0;
                end
`endif
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ga23_cpu_bridge.sv
// tb_ga23_cpu_bridge
//   Directed bench for ga23_cpu_bridge with a small behavioural GA23 model
//   (VRAM array, busy that rises after a strobe edge and holds busy_len
//   cycles, optional "ignore next strobe" to force the retry path).
//   Expected values under GA23_BRIDGE_RMW_EN differ for partial writes.
module tb_ga23_cpu_bridge;
    import ga23_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cpu_req = 1'b0;
    logic        cpu_io = 1'b0;
    logic        cpu_we = 1'b0;
    logic [1:0]  cpu_be = 2'b11;
    logic [15:0] cpu_addr = '0;
    logic [15:0] cpu_wdata = '0;
    logic [15:0] cpu_rdata;
    logic        cpu_ack;
    logic        ga_cs, ga_rd, ga_wr, ga_io_wr;
    logic [15:0] ga_addr, ga_din;
    logic [15:0] ga_dout = '0;
    logic        ga_busy = 1'b0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ga23_cpu_bridge #(.TIMEOUT(64), .ADDR_W(16)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_io(cpu_io), .cpu_we(cpu_we), .cpu_be(cpu_be),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
        .ga_cs(ga_cs), .ga_rd(ga_rd), .ga_wr(ga_wr), .ga_io_wr(ga_io_wr),
        .ga_addr(ga_addr), .ga_din(ga_din),
        .ga_dout(ga_dout), .ga_busy(ga_busy)
    );

    // GA23 model: starts an access on the rising edge of cs&(rd|wr).
    logic [15:0] vram [0:255];
    int          busy_len = 5;
    bit          ignore_next = 1'b0;
    int          edge_count = 0;
    int          busy_cnt = 0;
    logic        strobe_q = 1'b0;
    logic [15:0] m_addr = '0;
    logic [15:0] m_din = '0;
    logic        m_we = 1'b0;
    wire         strobe_now = ga_cs & (ga_rd | ga_wr);

    always @(posedge clk) begin
        if (reset) begin
            ga_busy  <= 1'b0;
            strobe_q <= 1'b0;
            busy_cnt = 0;
        end else begin
            strobe_q <= strobe_now;
            if (strobe_now && !strobe_q) begin
                edge_count++;
                if (ignore_next) begin
                    ignore_next = 1'b0;
                end else begin
                    busy_cnt = busy_len;
                    ga_busy <= 1'b1;
                    m_addr  = ga_addr;
                    m_din   = ga_din;
                    m_we    = ga_wr;
                end
            end else if (busy_cnt > 0) begin
                busy_cnt--;
                if (busy_cnt == 0) begin
                    ga_busy <= 1'b0;
                    if (m_we) vram[m_addr[8:1]] <= m_din;
                    else      ga_dout <= vram[m_addr[8:1]];
                end
            end
        end
    end

    // Output monitor, sampled on the inactive edge.
    int          ack_count = 0;
    int          io_wr_cycles = 0;
    int          io_ack_same = 0;
    int          cs_cycles = 0;
    logic [15:0] io_addr_seen = '0;
    logic [15:0] io_din_seen = '0;

    always @(negedge clk) begin
        if (cpu_ack) ack_count++;
        if (ga_io_wr) begin
            io_wr_cycles++;
            io_addr_seen = ga_addr;
            io_din_seen  = ga_din;
        end
        if (ga_io_wr && cpu_ack) io_ack_same++;
        if (ga_cs) cs_cycles++;
    end

    bit cs_trace[$];

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Issue one request and wait (bounded) for its ack, recording the cs
    // trace; ends one idle cycle after the ack so the next request lands
    // in IDLE.
    task automatic applyStimulus(input logic io, input logic we, input logic [1:0] be,
                                 input logic [15:0] addr, input logic [15:0] data,
                                 output bit acked, output logic [15:0] rdata,
                                 output int lat, output logic cs_at_ack);
        cs_trace.delete();
        @(negedge clk);
        cpu_req = 1'b1; cpu_io = io; cpu_we = we; cpu_be = be;
        cpu_addr = addr; cpu_wdata = data;
        @(negedge clk);
        cpu_req = 1'b0;
        lat = 1;
        cs_trace.push_back(ga_cs);
        while (!cpu_ack && lat < 400) begin
            @(negedge clk);
            lat++;
            cs_trace.push_back(ga_cs);
        end
        acked     = cpu_ack;
        rdata     = cpu_rdata;
        cs_at_ack = ga_cs;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no finish expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bit          acked;
        logic [15:0] rd;
        int          lat;
        logic        cs_ack;
        int          a0, e0, run1, run0, idx;

        for (int i = 0; i < 256; i++) vram[i] = 16'h0000;

        // Reset state
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("rst_strobes", {27'd0, ga_cs, ga_rd, ga_wr, ga_io_wr, cpu_ack}, 32'd0);
        checkOutput("rst_rdata", {16'd0, cpu_rdata}, 32'd0);
        checkOutput("rst_addr_din", {ga_addr, ga_din}, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Mem read 0x0100 -> BEEF, busy 5 cycles
        vram[8'h80] = 16'hBEEF;
        a0 = ack_count;
        applyStimulus(1'b0, 1'b0, 2'b11, 16'h0100, 16'h0000, acked, rd, lat, cs_ack);
        checkOutput("rd_ack", {31'd0, acked}, 32'd1);
        checkOutput("rd_data", {16'd0, rd}, 32'h0000BEEF);
        checkOutput("rd_lat_ge3", {31'd0, lat >= 3}, 32'd1);
        checkOutput("rd_cs_low_at_ack", {31'd0, cs_ack}, 32'd0);
        checkOutput("rd_one_ack", ack_count - a0, 32'd1);

        // Back-to-back writes
        e0 = edge_count;
        a0 = ack_count;
        applyStimulus(1'b0, 1'b1, 2'b11, 16'h0010, 16'h1234, acked, rd, lat, cs_ack);
        applyStimulus(1'b0, 1'b1, 2'b11, 16'h0012, 16'h5678, acked, rd, lat, cs_ack);
        checkOutput("wr_edges", edge_count - e0, 32'd2);
        checkOutput("wr_acks", ack_count - a0, 32'd2);
        checkOutput("wr_vram_10", {16'd0, vram[8'h08]}, 32'h00001234);
        checkOutput("wr_vram_12", {16'd0, vram[8'h09]}, 32'h00005678);

        // io write 0x9E = 0x0040
        io_wr_cycles = 0; io_ack_same = 0; cs_cycles = 0;
        a0 = ack_count;
        applyStimulus(1'b1, 1'b1, 2'b11, {8'h00, GA23_IO_BASE + 8'h1E}, 16'h0040, acked, rd, lat, cs_ack);
        checkOutput("io_lat", lat, 32'd1);
        checkOutput("io_wr_cycles", io_wr_cycles, 32'd1);
        checkOutput("io_addr", {16'd0, io_addr_seen}, 32'h0000009E);
        checkOutput("io_din", {16'd0, io_din_seen}, 32'h00000040);
        checkOutput("io_ack_same_cycle", io_ack_same, 32'd1);
        checkOutput("io_no_cs", cs_cycles, 32'd0);
        checkOutput("io_one_ack", ack_count - a0, 32'd1);

        // io read returns zero
        applyStimulus(1'b1, 1'b0, 2'b11, 16'h0082, 16'h0000, acked, rd, lat, cs_ack);
        checkOutput("io_rd_ack", {31'd0, acked}, 32'd1);
        checkOutput("io_rd_data", {16'd0, rd}, 32'd0);

        // Timeout/retry: first strobe ignored; odd address bit 0 ignored
        ignore_next = 1'b1;
        e0 = edge_count;
        a0 = ack_count;
        applyStimulus(1'b0, 1'b0, 2'b11, 16'h0101, 16'h0000, acked, rd, lat, cs_ack);
        run1 = 0; run0 = 0; idx = 0;
        while (idx < cs_trace.size() && cs_trace[idx]) begin run1++; idx++; end
        while (idx < cs_trace.size() && !cs_trace[idx]) begin run0++; idx++; end
        checkOutput("to_first_strobe_len", run1, 32'd64);
        checkOutput("to_gap_len", run0, 32'd1);
        checkOutput("to_edges", edge_count - e0, 32'd2);
        checkOutput("to_one_ack", ack_count - a0, 32'd1);
        checkOutput("to_data", {16'd0, rd}, 32'h0000BEEF);
        checkOutput("to_addr_bit0", {16'd0, m_addr}, 32'h00000100);

        // Partial write be=01
        vram[8'h10] = 16'hAABB;
        e0 = edge_count;
        applyStimulus(1'b0, 1'b1, 2'b01, 16'h0020, 16'h5511, acked, rd, lat, cs_ack);
        checkOutput("pw_ack", {31'd0, acked}, 32'd1);
`ifdef GA23_BRIDGE_RMW_EN
        checkOutput("pw_vram", {16'd0, vram[8'h10]}, 32'h0000AA11);
        checkOutput("pw_edges", edge_count - e0, 32'd2);
`else
        checkOutput("pw_vram", {16'd0, vram[8'h10]}, 32'h00001111);
        checkOutput("pw_edges", edge_count - e0, 32'd1);
`endif

        // Partial write be=10
        vram[8'h20] = 16'h1234;
        applyStimulus(1'b0, 1'b1, 2'b10, 16'h0040, 16'h77FF, acked, rd, lat, cs_ack);
`ifdef GA23_BRIDGE_RMW_EN
        checkOutput("pw_hi_vram", {16'd0, vram[8'h20]}, 32'h00007734);
`else
        checkOutput("pw_hi_vram", {16'd0, vram[8'h20]}, 32'h00007777);
`endif

        // be=00 behaves as full word
        vram[8'h18] = 16'h0000;
        applyStimulus(1'b0, 1'b1, 2'b00, 16'h0030, 16'hC0DE, acked, rd, lat, cs_ack);
        checkOutput("be00_vram", {16'd0, vram[8'h18]}, 32'h0000C0DE);

        // Reset during WAIT aborts without ack
        busy_len = 20;
        a0 = ack_count;
        @(negedge clk);
        cpu_req = 1'b1; cpu_io = 1'b0; cpu_we = 1'b0; cpu_be = 2'b11; cpu_addr = 16'h0100;
        @(negedge clk);
        cpu_req = 1'b0;
        repeat (5) @(negedge clk);
        checkOutput("in_wait", {30'd0, ga_cs, ga_busy}, 32'd3);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("rstw_strobes", {27'd0, ga_cs, ga_rd, ga_wr, ga_io_wr, cpu_ack}, 32'd0);
        checkOutput("rstw_rdata", {16'd0, cpu_rdata}, 32'd0);
        checkOutput("rstw_addr_din", {ga_addr, ga_din}, 32'd0);
        reset = 1'b0;
        busy_len = 5;
        repeat (3) @(negedge clk);
        checkOutput("rstw_no_ack", ack_count - a0, 32'd0);
        applyStimulus(1'b0, 1'b0, 2'b11, 16'h0100, 16'h0000, acked, rd, lat, cs_ack);
        checkOutput("post_rst_ack", {31'd0, acked}, 32'd1);
        checkOutput("post_rst_data", {16'd0, rd}, 32'h0000BEEF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
